// File: rtl/eros_ram_bank_arbiter.sv
// Round-robin arbiter giving NMASTER bus masters single-cycle access to one RAM bank.
// Grant is combinational (OBI style); the response follows one cycle later.
module eros_ram_bank_arbiter #(
    parameter int unsigned NMASTER    = 7,
    parameter logic [31:0] BANK_START = 32'h19020000,
    parameter logic [31:0] BANK_SIZE  = 32'h00008000,
    localparam int unsigned AW        = $clog2(BANK_SIZE) - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NMASTER-1:0]    req_i,
    input  logic [NMASTER-1:0]    we_i,
    input  logic [NMASTER*4-1:0]  be_i,
    input  logic [NMASTER*32-1:0] addr_i,
    input  logic [NMASTER*32-1:0] wdata_i,
    output logic [NMASTER-1:0]    gnt_o,
    output logic [NMASTER-1:0]    rvalid_o,
    output logic [NMASTER-1:0]    err_o,
    output logic [31:0]           rdata_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int unsigned IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;

    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_we;
    logic [31:0]   offset;
    logic          in_range;

    logic          rsp_valid_q;
    logic [IW-1:0] rsp_idx_q;
    logic          rsp_we_q;
    logic          rsp_err_q;

    // Search starts just past the last winner, wrapping at NMASTER.
    always_comb begin : rr_search
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        for (int unsigned i = 1; i <= NMASTER; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NMASTER) begin
                cand = cand - NMASTER;
            end
            cand_idx = IW'(cand);
            if (!gnt_any && req_i[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        if (rst_i) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        sel_addr  = addr_i[gnt_idx*32 +: 32];
        sel_wdata = wdata_i[gnt_idx*32 +: 32];
        sel_be    = be_i[gnt_idx*4 +: 4];
        sel_we    = we_i[gnt_idx];
        offset    = sel_addr - BANK_START;
        in_range  = (sel_addr >= BANK_START) && (offset < BANK_SIZE);
    end

    always_comb begin
        gnt_o       = '0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (gnt_any) begin
            gnt_o[gnt_idx] = 1'b1;
            if (in_range) begin
                ram_req_o   = 1'b1;
                ram_we_o    = sel_we;
                ram_be_o    = sel_be;
                ram_addr_o  = offset[AW+1:2];
                ram_wdata_o = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= IW'(NMASTER - 1);
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (gnt_any) begin
                last_q <= gnt_idx;
            end
            rsp_valid_q <= gnt_any;
            rsp_idx_q   <= gnt_idx;
            rsp_we_q    <= sel_we;
            rsp_err_q   <= !in_range;
        end
    end

    // Reset also masks the response combinationally so it drops in the same cycle.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = 32'h0;
        if (rsp_valid_q && !rst_i) begin
            rvalid_o[rsp_idx_q] = 1'b1;
            err_o[rsp_idx_q]    = rsp_err_q;
            if (rsp_err_q) begin
                rdata_o = 32'hBADACCE5;
            end else if (!rsp_we_q) begin
                rdata_o = ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_eros_ram_bank_arbiter.sv
// Directed bench for eros_ram_bank_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_eros_ram_bank_arbiter;

    localparam int NM = 7;
    localparam int AW = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NM-1:0]   req = '0;
    logic [NM-1:0]   we = '0;
    logic [NM*4-1:0] be = '0;
    logic [NM*32-1:0] addr = '0;
    logic [NM*32-1:0] wdata = '0;
    logic [NM-1:0]   gnt;
    logic [NM-1:0]   rvalid;
    logic [NM-1:0]   err;
    logic [31:0]     rdata;
    logic            ram_req;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    eros_ram_bank_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .be_i       (be),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .err_o      (err),
        .rdata_o    (rdata),
        .ram_req_o  (ram_req),
        .ram_we_o   (ram_we),
        .ram_be_o   (ram_be),
        .ram_addr_o (ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic r, input logic w,
                         input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d);
        req[m]         = r;
        we[m]          = w;
        be[m*4 +: 4]   = b;
        addr[m*32 +: 32]  = a;
        wdata[m*32 +: 32] = d;
    endtask

    task automatic idle_all();
        req   = '0;
        we    = '0;
        be    = '0;
        addr  = '0;
        wdata = '0;
    endtask

    initial begin
        // Reset with every master requesting
        for (int m = 0; m < NM; m++)
            drive(m, 1'b1, 1'b0, 4'hF, 32'h19020000 + 32'(m * 4), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ramreq", 32'(ram_req), 32'h0);

        // Round-robin over all seven, responses one cycle behind
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            ram_rdata = 32'hA5A50000 | 32'(c);
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1) << (c % 7));
            chk("rr_addr", 32'(ram_addr), 32'(c % 7));
            if (c == 0) begin
                chk("rr_rvalid0", 32'(rvalid), 32'h0);
            end else begin
                chk("rr_rvalid", 32'(rvalid), 32'(1) << ((c - 1) % 7));
                chk("rr_rdata", rdata, 32'hA5A50000 | 32'(c));
            end
        end

        // Idle: RAM outputs zero, last response from master 6
        @(negedge clk);
        idle_all();
        ram_rdata = 32'h11112222;
        #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_ramreq", 32'(ram_req), 32'h0);
        chk("idle_ramwe", 32'(ram_we), 32'h0);
        chk("idle_rambe", 32'(ram_be), 32'h0);
        chk("idle_ramaddr", 32'(ram_addr), 32'h0);
        chk("idle_ramwdata", ram_wdata, 32'h0);
        chk("idle_rvalid6", 32'(rvalid), 32'h40);
        @(negedge clk);
        #1;
        chk("idle2_rvalid", 32'(rvalid), 32'h0);
        chk("idle2_rdata", rdata, 32'h0);

        // Master 3 writes, master 5 reads back the same word
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 4'hF, 32'h19020010, 32'hCAFEF00D);
        #1;
        chk("wr_gnt", 32'(gnt), 32'h08);
        chk("wr_ramreq", 32'(ram_req), 32'h1);
        chk("wr_ramwe", 32'(ram_we), 32'h1);
        chk("wr_rambe", 32'(ram_be), 32'hF);
        chk("wr_ramaddr", 32'(ram_addr), 32'h4);
        chk("wr_ramwdata", ram_wdata, 32'hCAFEF00D);
        @(negedge clk);
        idle_all();
        drive(5, 1'b1, 1'b0, 4'hF, 32'h19020010, 32'h0);
        ram_rdata = 32'hDEADBEEF;
        #1;
        chk("wr_rvalid", 32'(rvalid), 32'h08);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_rdata", rdata, 32'h0);
        chk("rd_gnt", 32'(gnt), 32'h20);
        chk("rd_ramaddr", 32'(ram_addr), 32'h4);
        chk("rd_ramwe", 32'(ram_we), 32'h0);
        @(negedge clk);
        idle_all();
        ram_rdata = 32'hCAFEF00D;
        #1;
        chk("rd_rvalid", 32'(rvalid), 32'h20);
        chk("rd_err", 32'(err), 32'h0);
        chk("rd_rdata", rdata, 32'hCAFEF00D);

        // Master 1 reads first byte past the bank
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h19028000, 32'h0);
        #1;
        chk("oor_gnt", 32'(gnt), 32'h02);
        chk("oor_ramreq", 32'(ram_req), 32'h0);
        @(negedge clk);
        idle_all();
        ram_rdata = 32'h12345678;
        #1;
        chk("oor_rvalid", 32'(rvalid), 32'h02);
        chk("oor_err", 32'(err), 32'h02);
        chk("oor_rdata", rdata, 32'hBADACCE5);

        // Master 6 then 0 and 6 together: wrap gives 0 first
        @(negedge clk);
        drive(6, 1'b1, 1'b0, 4'hF, 32'h19020020, 32'h0);
        #1;
        chk("wrap_gnt6", 32'(gnt), 32'h40);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h19020000, 32'h0);
        #1;
        chk("wrap_gnt0", 32'(gnt), 32'h01);
        @(negedge clk);
        #1;
        chk("wrap_gnt6b", 32'(gnt), 32'h40);
        chk("wrap_rvalid0", 32'(rvalid), 32'h01);

        // Just below the bank, then the last word of the bank (last = 6)
        @(negedge clk);
        idle_all();
        drive(2, 1'b1, 1'b0, 4'hF, 32'h1901FFFC, 32'h0);
        #1;
        chk("low_gnt", 32'(gnt), 32'h04);
        chk("low_ramreq", 32'(ram_req), 32'h0);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 4'hF, 32'h19027FFC, 32'h0);
        #1;
        chk("low_err", 32'(err), 32'h04);
        chk("top_ramreq", 32'(ram_req), 32'h1);
        chk("top_ramaddr", 32'(ram_addr), 32'h1FFF);
        @(negedge clk);
        idle_all();
        // Zero byte-enable write still reaches the RAM
        drive(4, 1'b1, 1'b1, 4'h0, 32'h19020040, 32'h55AA55AA);
        #1;
        chk("top_err", 32'(err), 32'h0);
        chk("be0_gnt", 32'(gnt), 32'h10);
        chk("be0_ramreq", 32'(ram_req), 32'h1);
        chk("be0_rambe", 32'(ram_be), 32'h0);
        chk("be0_ramaddr", 32'(ram_addr), 32'h10);

        // Reset during a grant of master 2 discards it
        @(negedge clk);
        idle_all();
        drive(2, 1'b1, 1'b0, 4'hF, 32'h19020008, 32'h0);
        #1;
        chk("rg_gnt", 32'(gnt), 32'h04);
        rst = 1'b1;
        #1;
        chk("rg_gnt_rst", 32'(gnt), 32'h0);
        chk("rg_ramreq_rst", 32'(ram_req), 32'h0);
        @(negedge clk);
        #1;
        chk("rg_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h19020000, 32'h0);
        #1;
        chk("rg_rvalid2", 32'(rvalid), 32'h0);
        chk("rg_gnt0", 32'(gnt), 32'h01);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rg_gnt2", 32'(gnt), 32'h04);

        // Reset in the response cycle hides the response at once
        @(negedge clk);
        idle_all();
        ram_rdata = 32'h87654321;
        #1;
        chk("rr_pre", 32'(rvalid), 32'h04);
        rst = 1'b1;
        #1;
        chk("rr_rvalid_rst", 32'(rvalid), 32'h0);
        chk("rr_rdata_rst", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr_after", 32'(rvalid), 32'h0);

        // Master 4 streams eight reads back to back
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(4, 1'b1, 1'b0, 4'hF, 32'h19020100 + 32'(c * 4), 32'h0);
            ram_rdata = 32'h0BAD0000 | 32'(c);
            #1;
            chk("bb_gnt", 32'(gnt), 32'h10);
            chk("bb_ramaddr", 32'(ram_addr), 32'h40 + 32'(c));
            if (c == 0) begin
                chk("bb_rvalid0", 32'(rvalid), 32'h0);
            end else begin
                chk("bb_rvalid", 32'(rvalid), 32'h10);
                chk("bb_rdata", rdata, 32'h0BAD0000 | 32'(c));
            end
        end
        @(negedge clk);
        idle_all();
        ram_rdata = 32'h0BAD0008;
        #1;
        chk("bb_last", 32'(rvalid), 32'h10);
        chk("bb_last_rdata", rdata, 32'h0BAD0008);
        @(negedge clk);
        #1;
        chk("bb_done", 32'(rvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
